// File: rtl/mem_pkg.sv
// Shared definitions for the store path: func3 store encodings, the
// store_beat_unit FSM states, and width/legality helpers.
package mem_pkg;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;
  localparam logic [2:0] F3_SD = 3'b011;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_BEAT0 = 3'd1,
    ST_BEAT1 = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } state_t;

  // Bytes per bus beat.
  function automatic int nb_of(input int xlen);
    return xlen / 8;
  endfunction

  // Number of byte-offset bits inside one beat.
  function automatic int off_of(input int xlen);
    return $clog2(xlen / 8);
  endfunction

  // Store size in bytes encoded by func3[1:0].
  function automatic int size_of(input logic [2:0] f3);
    return int'(32'd1 << f3[1:0]);
  endfunction

  // Legality of a raw request: bad encoding, wider than the bus, or a
  // word-crossing store when splitting is disabled.
  function automatic logic req_illegal(input logic [2:0] f3, input int off,
                                       input int nb, input bit allow_split);
    int size;
    size = size_of(f3);
    return f3[2] || (size > nb) || (!allow_split && ((off + size) > nb));
  endfunction

endpackage

// File: rtl/store_lane_shift.sv
// Combinational lane shifter: places right-justified store data into byte
// lanes across a double-width window and builds the matching byte mask.
module store_lane_shift
  import mem_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0]            data,
  input  logic [off_of(XLEN)-1:0]    off,
  input  logic [2:0]                 func3,
  output logic [2*XLEN-1:0]          wide_data,
  output logic [2*nb_of(XLEN)-1:0]   wide_mask,
  output logic                       two_beat,
  output logic                       illegal
);

  localparam int NB = nb_of(XLEN);

  logic [2*NB-1:0]   base_mask;
  logic [2*XLEN-1:0] trunc;
  int                size;

  // Truncate to the store size, then shift data and mask up by the byte offset
  always_comb begin
    size      = size_of(func3);
    base_mask = '0;
    trunc     = '0;
    for (int i = 0; i < NB; i++) begin
      base_mask[i]     = (i < size);
      trunc[8*i +: 8]  = (i < size) ? data[8*i +: 8] : 8'h00;
    end
    wide_mask = base_mask << off;
    wide_data = trunc << {off, 3'b000};
    two_beat  = |wide_mask[2*NB-1:NB];
    illegal   = func3[2] || (size > NB);
  end

endmodule

// File: rtl/store_beat_unit.sv
// Store beat unit: accepts one store request, then emits one or two
// lane-aligned memory beats (splitting word-crossing stores) and reports
// completion or rejection with a single-cycle pulse.
module store_beat_unit
  import mem_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int AW             = 32,
  parameter int ALLOW_MISALIGN = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [XLEN-1:0]     store_data,
  input  logic [AW-1:0]       addr,
  input  logic [2:0]          func3,
  output logic                mem_valid,
  input  logic                mem_ready,
  output logic [AW-1:0]       mem_addr,
  output logic [XLEN-1:0]     mem_wdata,
  output logic [XLEN/8-1:0]   w_mask,
  output logic                store_done,
  output logic                store_err
);

  localparam int NB  = nb_of(XLEN);
  localparam int OFF = off_of(XLEN);

  state_t            state;
  state_t            state_next;
  logic [XLEN-1:0]   req_data;
  logic [AW-1:0]     req_addr;
  logic [2:0]        req_func3;
  logic [2*XLEN-1:0] wide_data;
  logic [2*NB-1:0]   wide_mask;
  logic              two_beat;
  logic              illegal;
  logic [AW-1:0]     beat_base;
  logic              accept;
  logic              req_bad;

  assign accept    = req_valid && (state == ST_IDLE);
  assign req_bad   = req_illegal(func3, int'(addr[OFF-1:0]), NB, (ALLOW_MISALIGN != 0));
  assign beat_base = {req_addr[AW-1:OFF], {OFF{1'b0}}};

  store_lane_shift #(.XLEN(XLEN)) u_shift (
    .data      (req_data),
    .off       (req_addr[OFF-1:0]),
    .func3     (req_func3),
    .wide_data (wide_data),
    .wide_mask (wide_mask),
    .two_beat  (two_beat),
    .illegal   (illegal)
  );

  // State register and request capture; the request is held for the whole store
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      req_data  <= '0;
      req_addr  <= '0;
      req_func3 <= 3'b000;
    end else begin
      state <= state_next;
      if (accept) begin
        req_data  <= store_data;
        req_addr  <= addr;
        req_func3 <= func3;
      end else begin
        req_data  <= req_data;
        req_addr  <= req_addr;
        req_func3 <= req_func3;
      end
    end
  end

  // Next-state and output decode; outputs depend only on registered state,
  // so beats stay stable while mem_ready is low
  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    mem_valid  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    w_mask     = '0;
    store_done = 1'b0;
    store_err  = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_next = req_bad ? ST_ERR : ST_BEAT0;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_BEAT0: begin
        // illegal never reaches this state; gating keeps a corrupted
        // request from ever producing a write
        mem_valid = !illegal;
        mem_addr  = beat_base;
        mem_wdata = wide_data[XLEN-1:0];
        w_mask    = wide_mask[NB-1:0];
        if (mem_ready) begin
          state_next = two_beat ? ST_BEAT1 : ST_DONE;
        end else begin
          state_next = ST_BEAT0;
        end
      end
      ST_BEAT1: begin
        mem_valid = !illegal;
        mem_addr  = beat_base + AW'(NB);
        mem_wdata = wide_data[2*XLEN-1:XLEN];
        w_mask    = wide_mask[2*NB-1:NB];
        if (mem_ready) begin
          state_next = ST_DONE;
        end else begin
          state_next = ST_BEAT1;
        end
      end
      ST_DONE: begin
        store_done = 1'b1;
        state_next = ST_IDLE;
      end
      ST_ERR: begin
        store_err  = 1'b1;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_store_beat_unit.sv
// Bench for store_beat_unit: three instances (32-bit split, 32-bit no-split,
// 64-bit split), a vector table feeding a scoreboard queue, and hand-written
// sequences for timing, back-pressure, error and mid-store reset.
module tb_store_beat_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [2:0]  rv;
  logic [63:0] sd;
  logic [31:0] ad;
  logic [2:0]  f3;
  logic        mready;

  logic        rr0, mv0, dn0, er0;
  logic [31:0] ma0, wd0;
  logic [3:0]  wm0;
  logic        rr1, mv1, dn1, er1;
  logic [31:0] ma1, wd1;
  logic [3:0]  wm1;
  logic        rr2, mv2, dn2, er2;
  logic [31:0] ma2;
  logic [63:0] wd2;
  logic [7:0]  wm2;

  store_beat_unit #(.XLEN(32), .AW(32), .ALLOW_MISALIGN(1)) dut0 (
    .clk(clk), .rst(rst), .req_valid(rv[0]), .req_ready(rr0), .store_data(sd[31:0]),
    .addr(ad), .func3(f3), .mem_valid(mv0), .mem_ready(mready), .mem_addr(ma0),
    .mem_wdata(wd0), .w_mask(wm0), .store_done(dn0), .store_err(er0));

  store_beat_unit #(.XLEN(32), .AW(32), .ALLOW_MISALIGN(0)) dut1 (
    .clk(clk), .rst(rst), .req_valid(rv[1]), .req_ready(rr1), .store_data(sd[31:0]),
    .addr(ad), .func3(f3), .mem_valid(mv1), .mem_ready(mready), .mem_addr(ma1),
    .mem_wdata(wd1), .w_mask(wm1), .store_done(dn1), .store_err(er1));

  store_beat_unit #(.XLEN(64), .AW(32), .ALLOW_MISALIGN(1)) dut2 (
    .clk(clk), .rst(rst), .req_valid(rv[2]), .req_ready(rr2), .store_data(sd),
    .addr(ad), .func3(f3), .mem_valid(mv2), .mem_ready(mready), .mem_addr(ma2),
    .mem_wdata(wd2), .w_mask(wm2), .store_done(dn2), .store_err(er2));

  // Selected-instance view of the outputs
  int          sel = 0;
  logic        o_rr, o_mv, o_dn, o_er;
  logic [31:0] o_ma;
  logic [63:0] o_wd;
  logic [7:0]  o_wm;

  always_comb begin
    case (sel)
      1: begin
        o_rr = rr1; o_mv = mv1; o_dn = dn1; o_er = er1;
        o_ma = ma1; o_wd = {32'h0, wd1}; o_wm = {4'h0, wm1};
      end
      2: begin
        o_rr = rr2; o_mv = mv2; o_dn = dn2; o_er = er2;
        o_ma = ma2; o_wd = wd2; o_wm = wm2;
      end
      default: begin
        o_rr = rr0; o_mv = mv0; o_dn = dn0; o_er = er0;
        o_ma = ma0; o_wd = {32'h0, wd0}; o_wm = {4'h0, wm0};
      end
    endcase
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: expected events in order (0 = beat, 1 = done, 2 = error)
  typedef struct {
    int          kind;
    logic [31:0] a;
    logic [7:0]  m;
    logic [63:0] d;
  } exp_t;

  exp_t exp_q[$];
  bit   mon_en = 1'b0;
  exp_t e;

  always @(negedge clk) begin
    if (mon_en) begin
      if (o_mv && mready) begin
        if (exp_q.size() == 0) begin
          check("beat_unexpected", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("beat_kind", 64'd0, 64'(e.kind));
          check("beat_addr", {32'h0, o_ma}, {32'h0, e.a});
          check("beat_mask", {56'h0, o_wm}, {56'h0, e.m});
          check("beat_data", o_wd, e.d);
        end
      end
      if (o_dn) begin
        if (exp_q.size() == 0) begin
          check("done_unexpected", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("done_kind", 64'd1, 64'(e.kind));
        end
      end
      if (o_er) begin
        if (exp_q.size() == 0) begin
          check("err_unexpected", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("err_kind", 64'd2, 64'(e.kind));
        end
      end
    end
  end

  typedef struct {
    int          dut;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [63:0] data;
    bit          err;
    int          nbeats;
    logic [31:0] a0;
    logic [7:0]  m0;
    logic [63:0] d0;
    logic [31:0] a1;
    logic [7:0]  m1;
    logic [63:0] d1;
  } vec_t;

  vec_t tbl[$];

  task automatic drive_req(input int s, input logic [2:0] f, input logic [31:0] a,
                           input logic [63:0] d);
    @(posedge clk); #1;
    sel = s; f3 = f; ad = a; sd = d;
    rv = 3'(3'b001 << s);
    @(posedge clk); #1;
    rv = 3'b000;
  endtask

  task automatic run_vec(input vec_t v);
    exp_t x;
    if (v.err) begin
      x = '{2, 32'h0, 8'h0, 64'h0}; exp_q.push_back(x);
    end else begin
      x = '{0, v.a0, v.m0, v.d0}; exp_q.push_back(x);
      if (v.nbeats == 2) begin
        x = '{0, v.a1, v.m1, v.d1}; exp_q.push_back(x);
      end
      x = '{1, 32'h0, 8'h0, 64'h0}; exp_q.push_back(x);
    end
    drive_req(v.dut, v.f3, v.addr, v.data);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    if (exp_q.size() != 0) begin
      check("store_timeout", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rv = 3'b000; sd = 64'h0; ad = 32'h0; f3 = 3'b000; mready = 1'b1;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready0", {63'h0, rr0}, 64'd1);
    check("rst_valid0", {63'h0, mv0}, 64'd0);
    check("rst_addr0",  {32'h0, ma0}, 64'd0);
    check("rst_data0",  {32'h0, wd0}, 64'd0);
    check("rst_mask0",  {60'h0, wm0}, 64'd0);
    check("rst_done0",  {63'h0, dn0}, 64'd0);
    check("rst_err0",   {63'h0, er0}, 64'd0);
    check("rst_ready2", {63'h0, rr2}, 64'd1);
    check("rst_data2",  wd2, 64'd0);
    rst = 1'b0;

    // Vector table: dut, func3, addr, data, err, beats, beat0, beat1
    tbl.push_back('{0, 3'b010, 32'h100, 64'h12345678, 1'b0, 1, 32'h100, 8'h0F, 64'h12345678, 32'h0, 8'h0, 64'h0});
    tbl.push_back('{0, 3'b000, 32'h103, 64'h12345678, 1'b0, 1, 32'h100, 8'h08, 64'h78000000, 32'h0, 8'h0, 64'h0});
    tbl.push_back('{0, 3'b001, 32'h102, 64'h12345678, 1'b0, 1, 32'h100, 8'h0C, 64'h56780000, 32'h0, 8'h0, 64'h0});
    tbl.push_back('{0, 3'b010, 32'h102, 64'h12345678, 1'b0, 2, 32'h100, 8'h0C, 64'h56780000, 32'h104, 8'h03, 64'h00001234});
    tbl.push_back('{0, 3'b000, 32'h101, 64'hAABBCCDD, 1'b0, 1, 32'h100, 8'h02, 64'h0000DD00, 32'h0, 8'h0, 64'h0});
    tbl.push_back('{0, 3'b001, 32'h103, 64'hAABBCCDD, 1'b0, 2, 32'h100, 8'h08, 64'hDD000000, 32'h104, 8'h01, 64'h000000CC});
    tbl.push_back('{0, 3'b010, 32'h1001, 64'hCAFEBABE, 1'b0, 2, 32'h1000, 8'h0E, 64'hFEBABE00, 32'h1004, 8'h01, 64'h000000CA});
    tbl.push_back('{0, 3'b100, 32'h100, 64'h12345678, 1'b1, 0, 32'h0, 8'h0, 64'h0, 32'h0, 8'h0, 64'h0});
    tbl.push_back('{0, 3'b011, 32'h100, 64'h12345678, 1'b1, 0, 32'h0, 8'h0, 64'h0, 32'h0, 8'h0, 64'h0});
    tbl.push_back('{0, 3'b010, 32'hFFFFFFFE, 64'h12345678, 1'b0, 2, 32'hFFFFFFFC, 8'h0C, 64'h56780000, 32'h0, 8'h03, 64'h00001234});
    tbl.push_back('{1, 3'b010, 32'h102, 64'h12345678, 1'b1, 0, 32'h0, 8'h0, 64'h0, 32'h0, 8'h0, 64'h0});
    tbl.push_back('{1, 3'b010, 32'h104, 64'h12345678, 1'b0, 1, 32'h104, 8'h0F, 64'h12345678, 32'h0, 8'h0, 64'h0});
    tbl.push_back('{1, 3'b001, 32'h103, 64'h12345678, 1'b1, 0, 32'h0, 8'h0, 64'h0, 32'h0, 8'h0, 64'h0});
    tbl.push_back('{1, 3'b000, 32'h103, 64'h12345678, 1'b0, 1, 32'h100, 8'h08, 64'h78000000, 32'h0, 8'h0, 64'h0});
    tbl.push_back('{2, 3'b011, 32'h1004, 64'h0123456789ABCDEF, 1'b0, 2, 32'h1000, 8'hF0, 64'h89ABCDEF00000000, 32'h1008, 8'h0F, 64'h0000000001234567});
    tbl.push_back('{2, 3'b011, 32'h1000, 64'h0123456789ABCDEF, 1'b0, 1, 32'h1000, 8'hFF, 64'h0123456789ABCDEF, 32'h0, 8'h0, 64'h0});
    tbl.push_back('{2, 3'b010, 32'h1006, 64'h0123456789ABCDEF, 1'b0, 2, 32'h1000, 8'hC0, 64'hCDEF000000000000, 32'h1008, 8'h03, 64'h00000000000089AB});
    tbl.push_back('{2, 3'b111, 32'h1000, 64'h0123456789ABCDEF, 1'b1, 0, 32'h0, 8'h0, 64'h0, 32'h0, 8'h0, 64'h0});

    mon_en = 1'b1;
    for (int i = 0; i < tbl.size(); i++) begin
      run_vec(tbl[i]);
    end
    mon_en = 1'b0;
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    // Cycle timing of a single-beat store with mem_ready high
    mready = 1'b1;
    drive_req(0, 3'b010, 32'h100, 64'h12345678);
    @(negedge clk);
    check("t_valid_n1", {63'h0, o_mv}, 64'd1);
    check("t_ready_n1", {63'h0, o_rr}, 64'd0);
    @(negedge clk);
    check("t_done_n2",  {63'h0, o_dn}, 64'd1);
    check("t_valid_n2", {63'h0, o_mv}, 64'd0);
    @(negedge clk);
    check("t_ready_n3", {63'h0, o_rr}, 64'd1);
    check("t_done_n3",  {63'h0, o_dn}, 64'd0);

    // Back-pressure on beat 0 of a split store
    mready = 1'b0;
    drive_req(0, 3'b010, 32'h102, 64'h12345678);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_valid", {63'h0, o_mv}, 64'd1);
      check("stall_addr",  {32'h0, o_ma}, 64'h100);
      check("stall_mask",  {56'h0, o_wm}, 64'h0C);
      check("stall_data",  o_wd, 64'h56780000);
      check("stall_ready", {63'h0, o_rr}, 64'd0);
    end
    mready = 1'b1;
    @(negedge clk);
    check("stall_b1_addr", {32'h0, o_ma}, 64'h104);
    check("stall_b1_mask", {56'h0, o_wm}, 64'h03);
    check("stall_b1_data", o_wd, 64'h00001234);
    @(negedge clk);
    check("stall_done", {63'h0, o_dn}, 64'd1);
    @(negedge clk);
    check("stall_idle", {63'h0, o_rr}, 64'd1);

    // Error timing
    drive_req(0, 3'b100, 32'h100, 64'h12345678);
    @(negedge clk);
    check("err_n1",       {63'h0, o_er}, 64'd1);
    check("err_novalid",  {63'h0, o_mv}, 64'd0);
    check("err_notready", {63'h0, o_rr}, 64'd0);
    @(negedge clk);
    check("err_ready_n2", {63'h0, o_rr}, 64'd1);
    check("err_clear_n2", {63'h0, o_er}, 64'd0);

    // Reset during beat 1 of a 64-bit split store
    drive_req(2, 3'b011, 32'h1004, 64'h0123456789ABCDEF);
    @(negedge clk);
    check("r_b0_addr", {32'h0, o_ma}, 64'h1000);
    @(negedge clk);
    check("r_b1_addr", {32'h0, o_ma}, 64'h1008);
    check("r_b1_mask", {56'h0, o_wm}, 64'h0F);
    rst = 1'b1;
    mready = 1'b0;
    @(negedge clk);
    check("r_valid", {63'h0, o_mv}, 64'd0);
    check("r_ready", {63'h0, o_rr}, 64'd1);
    check("r_addr",  {32'h0, o_ma}, 64'd0);
    check("r_data",  o_wd, 64'd0);
    check("r_done",  {63'h0, o_dn}, 64'd0);
    rst = 1'b0;
    mready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("r_no_done", {63'h0, o_dn}, 64'd0);
      check("r_no_valid", {63'h0, o_mv}, 64'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
